// File: rtl/exp_gate_array_if.sv
// Bus bundle for exp_gate_array: gate inputs, mask/counter control and the
// X/XBAR result pair with its strobe and the combinational expansion term.
interface exp_gate_array_if #(
    parameter int GROUPS = 2,
    parameter int WIDTH  = 2,
    parameter int CNT_W  = 8
);
    logic [GROUPS*WIDTH-1:0] in;
    logic                    in_valid;
    logic                    exp_in;
    logic                    mask_ld;
    logic [GROUPS-1:0]       mask_data;
    logic                    cnt_clr;
    logic                    x;
    logic                    xbar;
    logic                    out_valid;
    logic                    exp_out;
    logic [CNT_W-1:0]        toggle_cnt;

    modport master (
        output in, in_valid, exp_in, mask_ld, mask_data, cnt_clr,
        input  x, xbar, out_valid, exp_out, toggle_cnt
    );

    modport slave (
        input  in, in_valid, exp_in, mask_ld, mask_data, cnt_clr,
        output x, xbar, out_valid, exp_out, toggle_cnt
    );
endinterface

// File: rtl/exp_gate_array.sv
// Pipelined AND-OR-INVERT expander: masked OR of per-group ANDs plus an
// expansion term, two-stage registered X/XBAR and a saturating toggle counter.
module exp_gate_group #(
    parameter int WIDTH = 2
) (
    input  logic [WIDTH-1:0] a,
    input  logic             en,
    output logic             m
);
    assign m = (&a) & en;
endmodule

module exp_gate_array #(
    parameter int GROUPS = 2,
    parameter int WIDTH  = 2,
    parameter int CNT_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    exp_gate_array_if.slave    bus
);
    localparam int STAGES = 2;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [GROUPS-1:0][WIDTH-1:0] grp;
    logic [GROUPS-1:0]            mask;
    logic [GROUPS-1:0]            m;
    logic                         sum_comb;
    logic [STAGES:1]              vld_pipe;
    logic                         s1_sum;
    logic                         x_q;
    logic                         xbar_q;
    logic [CNT_W-1:0]             cnt;
    logic                         toggle;

    assign grp = bus.in;

    for (genvar g = 0; g < GROUPS; g++) begin : g_grp
        exp_gate_group #(.WIDTH(WIDTH)) u_grp (
            .a  (grp[g]),
            .en (mask[g]),
            .m  (m[g])
        );
    end

    // Expansion output deliberately excludes exp_in so cascades stay loop-free.
    assign sum_comb    = |m;
    assign bus.exp_out = sum_comb;

    assign toggle = vld_pipe[1] && (s1_sum != x_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            mask     <= '1;
            vld_pipe <= '0;
            s1_sum   <= 1'b0;
            x_q      <= 1'b0;
            xbar_q   <= 1'b1;
            cnt      <= '0;
        end else begin
            if (bus.mask_ld)
                mask <= bus.mask_data;
            vld_pipe <= {vld_pipe[STAGES-1:1], bus.in_valid};
            if (bus.in_valid)
                s1_sum <= sum_comb | bus.exp_in;
            if (vld_pipe[1]) begin
                x_q    <= s1_sum;
                xbar_q <= ~s1_sum;
            end
            if (bus.cnt_clr)
                cnt <= '0;
            else if (toggle && cnt != CNT_MAX)
                cnt <= cnt + 1'b1;
        end
    end

    assign bus.x          = x_q;
    assign bus.xbar       = xbar_q;
    assign bus.out_valid  = vld_pipe[STAGES];
    assign bus.toggle_cnt = cnt;
endmodule

// File: tb/tb_exp_gate_array.sv
// Self-checking bench for exp_gate_array: directed vector table, randomized
// run against a history-based reference model, and a two-array cascade.
module tb_exp_gate_array;
    localparam int G  = 2;
    localparam int W  = 2;
    localparam int CW = 3;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst;
    logic rst_c;
    always #5 clk = ~clk;

    exp_gate_array_if #(.GROUPS(G), .WIDTH(W), .CNT_W(CW)) bus ();
    exp_gate_array_if #(.GROUPS(2), .WIDTH(2), .CNT_W(8))  up ();
    exp_gate_array_if #(.GROUPS(2), .WIDTH(2), .CNT_W(8))  dn ();

    exp_gate_array #(.GROUPS(G), .WIDTH(W), .CNT_W(CW)) u_dut (.clk(clk), .rst(rst),   .bus(bus));
    exp_gate_array #(.GROUPS(2), .WIDTH(2), .CNT_W(8))  u_up  (.clk(clk), .rst(rst_c), .bus(up));
    exp_gate_array #(.GROUPS(2), .WIDTH(2), .CNT_W(8))  u_dn  (.clk(clk), .rst(rst_c), .bus(dn));

    assign dn.exp_in = up.exp_out;

    int errs   = 0;
    int checks = 0;

    // reference model state: result sampled at the previous edge, delivered at the next
    logic [G-1:0] m_mask = '1;
    logic m_known = 1'b0;
    logic m_pv = 1'b0, m_ps = 1'b0, m_x = 1'b0, m_ov = 1'b0;
    int   m_cnt = 0;

    typedef struct {
        logic       r;
        logic [3:0] i;
        logic       v, e, ld;
        logic [1:0] md;
        logic       clr;
        logic       x, ov;
        int         cnt;
    } vec_t;
    vec_t tbl[$];

    function automatic logic or_terms(input logic [G*W-1:0] v, input logic [G-1:0] mk);
        logic res = 1'b0;
        for (int g = 0; g < G; g++) begin
            logic all1 = 1'b1;
            for (int k = 0; k < W; k++)
                if (v[g*W+k] !== 1'b1) all1 = 1'b0;
            if (all1 && mk[g]) res = 1'b1;
        end
        return res;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s @%0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [3:0] i, input logic v, input logic e,
                       input logic ld, input logic [1:0] md, input logic clr,
                       input logic x, input logic ov, input int cnt);
        vec_t t;
        t.r = r; t.i = i; t.v = v; t.e = e; t.ld = ld; t.md = md; t.clr = clr;
        t.x = x; t.ov = ov; t.cnt = cnt;
        tbl.push_back(t);
    endtask

    task automatic step(input int idx, input logic r, input logic [3:0] i, input logic v,
                        input logic e, input logic ld, input logic [1:0] md, input logic clr);
        rst = r; bus.in = i; bus.in_valid = v; bus.exp_in = e;
        bus.mask_ld = ld; bus.mask_data = md; bus.cnt_clr = clr;
        #1;
        if (m_known) chk("exp_out", idx, {31'd0, bus.exp_out}, {31'd0, or_terms(i, m_mask)});
        @(posedge clk);
        if (r) begin
            m_known = 1'b1; m_mask = '1; m_pv = 1'b0; m_ps = 1'b0;
            m_x = 1'b0; m_ov = 1'b0; m_cnt = 0;
        end else begin
            m_ov = m_pv;
            if (m_pv) begin
                if (m_ps != m_x && m_cnt < CMAX) m_cnt++;
                m_x = m_ps;
            end
            if (clr) m_cnt = 0;
            if (v) m_ps = e | or_terms(i, m_mask);
            m_pv = v;
            if (ld) m_mask = md;
        end
        #1;
        if (m_known) begin
            chk("model_x",    idx, {31'd0, bus.x},         {31'd0, m_x});
            chk("model_xbar", idx, {31'd0, bus.xbar},      {31'd0, ~m_x});
            chk("model_ov",   idx, {31'd0, bus.out_valid}, {31'd0, m_ov});
            chk("model_cnt",  idx, {29'd0, bus.toggle_cnt}, m_cnt);
        end
    endtask

    initial begin
        rst = 1'b1; rst_c = 1'b1;
        bus.in = '0; bus.in_valid = 1'b0; bus.exp_in = 1'b0;
        bus.mask_ld = 1'b0; bus.mask_data = '0; bus.cnt_clr = 1'b0;
        up.in = '0; up.in_valid = 1'b0; up.exp_in = 1'b0;
        up.mask_ld = 1'b0; up.mask_data = '0; up.cnt_clr = 1'b0;
        dn.in = '0; dn.in_valid = 1'b0;
        dn.mask_ld = 1'b0; dn.mask_data = '0; dn.cnt_clr = 1'b0;

        //   r  in       v  e  ld md     clr   x  ov cnt (after this edge)
        add(1, 4'b0000, 0, 0, 0, 2'b00, 0,    0, 0, 0);
        add(1, 4'b0000, 0, 0, 0, 2'b00, 0,    0, 0, 0);
        add(0, 4'b0100, 1, 0, 0, 2'b00, 0,    0, 0, 0);
        add(0, 4'b1100, 1, 0, 0, 2'b00, 0,    0, 1, 0);
        add(0, 4'b0011, 1, 0, 0, 2'b00, 0,    1, 1, 1);
        add(0, 4'b0000, 0, 0, 0, 2'b00, 0,    1, 1, 1);
        add(0, 4'b0000, 1, 0, 0, 2'b00, 0,    1, 0, 1);
        add(0, 4'b0000, 0, 0, 0, 2'b00, 0,    0, 1, 2);
        add(0, 4'b0011, 1, 0, 1, 2'b10, 0,    0, 0, 2);
        add(0, 4'b0011, 1, 0, 0, 2'b00, 0,    1, 1, 3);
        add(0, 4'b1100, 1, 0, 0, 2'b00, 0,    0, 1, 4);
        add(0, 4'b0000, 0, 0, 0, 2'b00, 0,    1, 1, 5);
        add(0, 4'b0000, 1, 0, 0, 2'b00, 0,    1, 0, 5);
        add(0, 4'b0000, 1, 1, 0, 2'b00, 0,    0, 1, 6);
        add(0, 4'b0000, 0, 0, 1, 2'b11, 1,    1, 1, 0);
        add(0, 4'b0000, 1, 0, 0, 2'b00, 0,    1, 0, 0);
        add(0, 4'b0011, 1, 0, 0, 2'b00, 0,    0, 1, 1);
        add(0, 4'b0000, 1, 0, 0, 2'b00, 0,    1, 1, 2);
        add(0, 4'b0011, 1, 0, 0, 2'b00, 0,    0, 1, 3);
        add(0, 4'b0000, 1, 0, 0, 2'b00, 0,    1, 1, 4);
        add(0, 4'b0011, 1, 0, 0, 2'b00, 0,    0, 1, 5);
        add(0, 4'b0000, 1, 0, 0, 2'b00, 0,    1, 1, 6);
        add(0, 4'b0011, 1, 0, 0, 2'b00, 0,    0, 1, 7);
        add(0, 4'b0000, 1, 0, 0, 2'b00, 0,    1, 1, 7);
        add(0, 4'b0011, 1, 0, 0, 2'b00, 0,    0, 1, 7);
        add(0, 4'b0000, 1, 0, 0, 2'b00, 1,    1, 1, 0);
        add(0, 4'b0011, 1, 0, 0, 2'b00, 0,    0, 1, 1);
        add(0, 4'b0011, 1, 0, 1, 2'b01, 0,    1, 1, 2);
        add(0, 4'b1100, 1, 0, 0, 2'b00, 0,    1, 1, 2);
        add(1, 4'b1100, 1, 0, 0, 2'b00, 0,    0, 0, 0);
        add(0, 4'b0000, 0, 0, 0, 2'b00, 0,    0, 0, 0);
        add(0, 4'b1100, 1, 0, 0, 2'b00, 0,    0, 0, 0);
        add(0, 4'b0000, 0, 0, 0, 2'b00, 0,    1, 1, 1);

        for (int k = 0; k < tbl.size(); k++) begin
            step(k, tbl[k].r, tbl[k].i, tbl[k].v, tbl[k].e, tbl[k].ld, tbl[k].md, tbl[k].clr);
            chk("tbl_x",    k, {31'd0, bus.x},          {31'd0, tbl[k].x});
            chk("tbl_xbar", k, {31'd0, bus.xbar},       {31'd0, ~tbl[k].x});
            chk("tbl_ov",   k, {31'd0, bus.out_valid},  {31'd0, tbl[k].ov});
            chk("tbl_cnt",  k, {29'd0, bus.toggle_cnt}, tbl[k].cnt);
        end

        for (int k = 0; k < 400; k++) begin
            logic [3:0] ri;
            logic [1:0] rmd;
            ri  = 4'($urandom_range(0, 15));
            rmd = 2'($urandom_range(0, 3));
            step(1000 + k, $urandom_range(0, 39) == 0, ri, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, rmd,
                 $urandom_range(0, 15) == 0);
        end

        // cascade: upstream product reaches downstream X through exp_in
        rst = 1'b1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_c = 1'b0;
        up.in = 4'b0011; up.in_valid = 1'b1;
        dn.in = 4'b0000; dn.in_valid = 1'b1;
        #1;
        chk("casc_up_exp_out", 0, {31'd0, up.exp_out}, 32'd1);
        chk("casc_dn_exp_out", 0, {31'd0, dn.exp_out}, 32'd0);
        @(posedge clk); #1;
        up.in = 4'b0000;
        @(posedge clk); #1;
        chk("casc_dn_x",  1, {31'd0, dn.x},         32'd1);
        chk("casc_dn_ov", 1, {31'd0, dn.out_valid}, 32'd1);
        chk("casc_up_x",  1, {31'd0, up.x},         32'd1);
        up.in_valid = 1'b0; dn.in_valid = 1'b0;
        @(posedge clk); #1;
        chk("casc_dn_x0", 2, {31'd0, dn.x}, 32'd0);
        chk("casc_dn_ov0", 2, {31'd0, dn.out_valid}, 32'd1);
        chk("casc_dn_cnt", 2, {24'd0, dn.toggle_cnt}, 32'd2);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/exp_gate_array.md
# exp_gate_array

Parametrised, pipelined AND-OR-INVERT expander gate array. It computes X = OR over GROUPS of (AND of WIDTH inputs), gated by a per-group enable mask and OR-ed with an expansion input, and drives complementary outputs X/XBAR. A combinational expansion output lets several arrays be cascaded into one wider OR term. A saturating transition counter on X supports activity/toggle characterisation in the microarchitecture circuit library. The default configuration (GROUPS=2, WIDTH=2) reproduces the 4-input AB+CD expander gate with registered outputs.

## Interface
- GROUPS, 2, number of AND groups (≥1)
- WIDTH, 2, inputs per AND group (≥1)
- CNT_W, 8, width of transition counter (≥1)
- CLK  input  1  clock, all state updates on rising edge
- RST  input  1  synchronous, active-high reset
- IN  input  GROUPS*WIDTH  gate inputs; group g = IN[g*WIDTH +: WIDTH]
- IN_VALID  input  1  IN and EXP_IN are valid this cycle
- EXP_IN  input  1  expansion term from an upstream array, OR-ed into the sum
- MASK_LD  input  1  load MASK_DATA into the group-enable mask
- MASK_DATA  input  GROUPS  new mask; bit g = 1 enables group g
- CNT_CLR  input  1  clear transition counter
- X  output  1  registered OR result
- XBAR  output  1  registered complement of X
- OUT_VALID  output  1  X/XBAR carry a new result this cycle
- EXP_OUT  output  1  combinational OR of masked products of the current IN (excludes EXP_IN)
- TOGGLE_CNT  output  CNT_W  count of X value changes, saturating

## Operation
- P[g] = &IN[g*WIDTH +: WIDTH]; M[g] = P[g] & MASK[g], where MASK is the register value before the current edge.
- EXP_OUT = |M, combinational, no dependency on EXP_IN (no combinational loop when cascading).
- Stage 1 (loads only when IN_VALID=1): S1_SUM <= (|M) | EXP_IN; S1_V <= IN_VALID every cycle.
- Stage 2 (loads only when S1_V=1): X <= S1_SUM; XBAR <= ~S1_SUM; OUT_VALID <= S1_V every cycle.
- When the inputs are invalid, the registers hold. X/XBAR keep their last value. XBAR == ~X at all times after reset.
- Mask: MASK <= MASK_DATA on an edge with MASK_LD=1. The new mask applies to IN sampled on the following edge, not the same edge.
- Counter: on an edge where stage 2 loads and S1_SUM != X, TOGGLE_CNT increments.
  - Saturates at 2^CNT_W-1; it never wraps.
  - CNT_CLR=1 forces 0 and has priority over an increment on the same edge.
- Reset (RST=1 at an edge):
  - X=0, XBAR=1, OUT_VALID=0, TOGGLE_CNT=0, MASK=all ones.
  - S1_SUM=0, S1_V=0.
  - Reset overrides MASK_LD, CNT_CLR and any in-flight data; results in flight are discarded, not completed.
- EXP_OUT is not reset. It follows IN and MASK combinationally, so it shows the reset mask of all ones during reset.

## Timing
- Latency 2 cycles: IN/IN_VALID sampled at edge t gives X/XBAR/OUT_VALID updated at edge t+1, visible in cycle t+2.
- Throughput 1 result/cycle. There is no backpressure; OUT_VALID is a one-cycle-per-result strobe.
- Bubbles (IN_VALID=0) propagate as OUT_VALID=0 two cycles later, with X held.
- Cascade: the upstream EXP_OUT feeds the downstream EXP_IN in the same cycle. Both arrays must share CLK and IN_VALID; the downstream X then covers both arrays with the same 2-cycle latency.
- TOGGLE_CNT updates on the same edge as X.

## Test plan
- Reset / default AB+CD:
  - Hold RST 2 cycles -> X=0, XBAR=1, OUT_VALID=0, TOGGLE_CNT=0.
  - Then IN=4'b0100 (C=1 only), valid -> X=0 two cycles later.
  - Then IN=4'b1100 (C=D=1) -> X=1, XBAR=0, TOGGLE_CNT=1.
- Pipeline/bubbles: stream IN=4'b0011, then 4'b0000 with IN_VALID=0, then 4'b0000 valid.
  - Required: OUT_VALID pattern 1,0,1 starting 2 cycles after the first input.
  - Required: X held at 1 through the bubble, then 0; TOGGLE_CNT=2.
- Mask:
  - Load MASK_DATA=2'b10 in the same cycle as IN=4'b0011 (valid) -> X=1, because the old mask applies.
  - Next IN=4'b0011 -> X=0.
  - IN=4'b1100 -> X=1.
  - EXP_OUT tracks |M combinationally in each cycle.
- Expansion: IN=0, EXP_IN=1, valid -> X=1 and EXP_OUT=0; cascade two instances, upstream IN=4'b0011 -> downstream X=1 after 2 cycles.
- Counter saturation/clear (CNT_W=3):
  - Alternate X 10 times -> TOGGLE_CNT sticks at 7.
  - CNT_CLR asserted on a toggling edge -> counter reads 0.
- Reset mid-stream: assert RST while two valid results are in flight -> OUT_VALID stays 0 for the next 2 cycles, X=0, MASK back to all ones.
